// File: rtl/main_mem_arbiter_if.sv
// Bundle of requester, memory and status signals around main_mem_arbiter.
// The master modport is the arbiter's view. The slave modport is the caches-plus-memory side.
interface main_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter int LINE_W = 512
);
  logic [ADDR_W-1:0] p0_addr;
  logic [WORD_W-1:0] p0_wdata;
  logic              p0_read_req;
  logic              p0_write_req;
  logic [LINE_W-1:0] p0_rdata;
  logic              p0_ready;
  logic              p0_err;

  logic [ADDR_W-1:0] p1_addr;
  logic [WORD_W-1:0] p1_wdata;
  logic              p1_read_req;
  logic              p1_write_req;
  logic [LINE_W-1:0] p1_rdata;
  logic              p1_ready;
  logic              p1_err;

  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_data_out;
  logic              mem_read_req;
  logic              mem_write_req;
  logic [LINE_W-1:0] mem_data_in;
  logic              mem_ready;

  logic              grant;
  logic              busy;

  modport master (
    input  p0_addr, p0_wdata, p0_read_req, p0_write_req,
    input  p1_addr, p1_wdata, p1_read_req, p1_write_req,
    input  mem_data_in, mem_ready,
    output p0_rdata, p0_ready, p0_err,
    output p1_rdata, p1_ready, p1_err,
    output mem_addr, mem_data_out, mem_read_req, mem_write_req,
    output grant, busy
  );

  modport slave (
    output p0_addr, p0_wdata, p0_read_req, p0_write_req,
    output p1_addr, p1_wdata, p1_read_req, p1_write_req,
    output mem_data_in, mem_ready,
    input  p0_rdata, p0_ready, p0_err,
    input  p1_rdata, p1_ready, p1_err,
    input  mem_addr, mem_data_out, mem_read_req, mem_write_req,
    input  grant, busy
  );
endinterface

// File: rtl/main_mem_arbiter.sv
// Round-robin arbiter that shares the main-memory port between I-cache (port 0) and D-cache (port 1).
// Define ARB_TIMEOUT_EN to add a WAIT watchdog that completes the transaction with pN_err set.
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_IDLE  | sample requests, pick a port, capture addr/wdata/op
// ST_ISSUE | one-cycle mem_read_req or mem_write_req pulse
// ST_WAIT  | wait for mem_ready (or the watchdog, when enabled)
// ST_DONE  | one-cycle ready pulse to the granted port
module main_mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int WORD_W         = 32,
  parameter int LINE_W         = 512,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  main_mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

  state_t            state;
  logic              last_grant;
  logic              grant_q;
  logic              op_write;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [LINE_W-1:0] line_buf;
  logic              rd_req_q;
  logic              wr_req_q;
  logic              rdy0_q;
  logic              rdy1_q;
  logic              busy_q;

  logic              req0;
  logic              req1;
  logic              sel;
  logic              sel_write;

  always_comb begin
    req0      = bus.p0_read_req | bus.p0_write_req;
    req1      = bus.p1_read_req | bus.p1_write_req;
    // On a tie the port that did not win last time goes next.
    sel       = (req0 & req1) ? ~last_grant : ~req0;
    sel_write = sel ? bus.p1_write_req : bus.p0_write_req;
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] tmo_cnt;
  logic             err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      grant_q    <= 1'b0;
      op_write   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      line_buf   <= '0;
      rd_req_q   <= 1'b0;
      wr_req_q   <= 1'b0;
      rdy0_q     <= 1'b0;
      rdy1_q     <= 1'b0;
      busy_q     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      tmo_cnt    <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      rdy0_q   <= 1'b0;
      rdy1_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      err_q    <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (req0 | req1) begin
            grant_q    <= sel;
            last_grant <= sel;
            addr_q     <= sel ? bus.p1_addr : bus.p0_addr;
            wdata_q    <= sel ? bus.p1_wdata : bus.p0_wdata;
            op_write   <= sel_write;
            rd_req_q   <= ~sel_write;
            wr_req_q   <= sel_write;
            busy_q     <= 1'b1;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT;
`ifdef ARB_TIMEOUT_EN
          tmo_cnt <= CNT_W'(TIMEOUT_CYCLES - 1);
`endif
        end
        ST_WAIT: begin
          if (bus.mem_ready) begin
            if (!op_write) line_buf <= bus.mem_data_in;
            rdy0_q <= ~grant_q;
            rdy1_q <= grant_q;
            state  <= ST_DONE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (tmo_cnt == '0) begin
            rdy0_q <= ~grant_q;
            rdy1_q <= grant_q;
            err_q  <= 1'b1;
            state  <= ST_DONE;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
`endif
        end
        ST_DONE: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_addr      = addr_q;
  assign bus.mem_data_out  = wdata_q;
  assign bus.mem_read_req  = rd_req_q;
  assign bus.mem_write_req = wr_req_q;
  assign bus.grant         = grant_q;
  assign bus.busy          = busy_q;
  assign bus.p0_ready      = rdy0_q;
  assign bus.p1_ready      = rdy1_q;
  // One shared line buffer, exposed only to the port being acknowledged.
  assign bus.p0_rdata      = rdy0_q ? line_buf : '0;
  assign bus.p1_rdata      = rdy1_q ? line_buf : '0;
`ifdef ARB_TIMEOUT_EN
  assign bus.p0_err        = err_q & rdy0_q;
  assign bus.p1_err        = err_q & rdy1_q;
`else
  assign bus.p0_err        = 1'b0;
  assign bus.p1_err        = 1'b0;
`endif

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Directed bench for main_mem_arbiter: the bench acts as both caches and the memory.
// Build with or without ARB_TIMEOUT_EN; the watchdog scenario adapts to the macro.
module tb_main_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int WORD_W = 32;
  localparam int LINE_W = 512;

  logic clk;
  logic rst;
  int   passed;
  int   total;
  int   rd_cnt;
  int   wr_cnt;
  int   rdy_cnt;

  main_mem_arbiter_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .LINE_W(LINE_W)) bus ();

  main_mem_arbiter #(
    .ADDR_W(ADDR_W), .WORD_W(WORD_W), .LINE_W(LINE_W), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_read_req === 1'b1) rd_cnt++;
    if (bus.mem_write_req === 1'b1) wr_cnt++;
    if (bus.p0_ready === 1'b1 || bus.p1_ready === 1'b1) rdy_cnt++;
  end

  task automatic clear_inputs();
    bus.p0_addr = '0; bus.p0_wdata = '0; bus.p0_read_req = 1'b0; bus.p0_write_req = 1'b0;
    bus.p1_addr = '0; bus.p1_wdata = '0; bus.p1_read_req = 1'b0; bus.p1_write_req = 1'b0;
    bus.mem_data_in = '0; bus.mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Bounded wait for the ISSUE cycle; returns at the negedge where the pulse is visible.
  task automatic wait_issue(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.mem_read_req === 1'b1 || bus.mem_write_req === 1'b1) ok = 1'b1;
    end
    total++;
    if (!ok) $display("FAIL issue_wait: no mem request seen within 20 cycles");
    else passed++;
  endtask

  // From the ISSUE negedge: mem_ready is sampled at the lat-th WAIT edge; returns at the DONE negedge.
  task automatic finish_mem(input int lat, input logic [LINE_W-1:0] data);
    repeat (lat) @(negedge clk);
    bus.mem_ready   = 1'b1;
    bus.mem_data_in = data;
    @(negedge clk);
    bus.mem_ready   = 1'b0;
    bus.mem_data_in = '0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else passed++;
    total++; if (bus.grant !== 1'b0) $display("FAIL reset_grant: got %b want 0", bus.grant); else passed++;
    total++; if (bus.mem_read_req !== 1'b0 || bus.mem_write_req !== 1'b0)
      $display("FAIL reset_mem_req: got rd=%b wr=%b want 0 0", bus.mem_read_req, bus.mem_write_req);
    else passed++;
    total++; if (bus.mem_addr !== '0 || bus.mem_data_out !== '0)
      $display("FAIL reset_mem_bus: got addr=%h data=%h want 0 0", bus.mem_addr, bus.mem_data_out);
    else passed++;
    total++; if (bus.p0_ready !== 1'b0 || bus.p1_ready !== 1'b0 || bus.p0_err !== 1'b0 || bus.p1_err !== 1'b0)
      $display("FAIL reset_ready_err: got %b%b%b%b want 0000", bus.p0_ready, bus.p1_ready, bus.p0_err, bus.p1_err);
    else passed++;
    total++; if (bus.p0_rdata !== '0 || bus.p1_rdata !== '0)
      $display("FAIL reset_rdata: got p0=%h p1=%h want 0", bus.p0_rdata, bus.p1_rdata);
    else passed++;
  endtask

  task automatic test_single_read();
    logic [LINE_W-1:0] d;
    int rd0;
    bit ok;
    d = {16{32'h0000_1000}};
    rd0 = rd_cnt;
    bus.p0_addr = 32'h1000; bus.p0_read_req = 1'b1;
    wait_issue(ok);
    total++; if (bus.mem_addr !== 32'h1000) $display("FAIL single_addr: got %h want 1000", bus.mem_addr); else passed++;
    total++; if (bus.grant !== 1'b0 || bus.busy !== 1'b1)
      $display("FAIL single_grant_busy: got grant=%b busy=%b want 0 1", bus.grant, bus.busy);
    else passed++;
    finish_mem(3, d);
    total++; if (bus.p0_ready !== 1'b1 || bus.p1_ready !== 1'b0 || bus.p0_err !== 1'b0)
      $display("FAIL single_ready: got p0=%b p1=%b err=%b want 1 0 0", bus.p0_ready, bus.p1_ready, bus.p0_err);
    else passed++;
    total++; if (bus.p0_rdata !== d) $display("FAIL single_rdata: got %h want %h", bus.p0_rdata, d); else passed++;
    bus.p0_read_req = 1'b0;
    @(negedge clk);
    total++; if (bus.p0_ready !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL single_after: got ready=%b busy=%b want 0 0", bus.p0_ready, bus.busy);
    else passed++;
    @(negedge clk);
    total++; if (rd_cnt - rd0 !== 1) $display("FAIL single_rd_pulses: got %0d want 1", rd_cnt - rd0); else passed++;
  endtask

  task automatic test_simultaneous();
    logic [LINE_W-1:0] d;
    bit ok;
    d = {16{32'hCAFE_0001}};
    do_reset();
    bus.p0_addr = 32'h1000; bus.p0_read_req = 1'b1;
    bus.p1_addr = 32'h2000; bus.p1_wdata = 32'hDEAD_BEEF; bus.p1_write_req = 1'b1;
    wait_issue(ok);
    total++; if (bus.grant !== 1'b0 || bus.mem_read_req !== 1'b1 || bus.mem_addr !== 32'h1000)
      $display("FAIL simul_first: got grant=%b rd=%b addr=%h want 0 1 1000", bus.grant, bus.mem_read_req, bus.mem_addr);
    else passed++;
    finish_mem(1, d);
    total++; if (bus.p0_ready !== 1'b1 || bus.p1_ready !== 1'b0)
      $display("FAIL simul_first_ready: got p0=%b p1=%b want 1 0", bus.p0_ready, bus.p1_ready);
    else passed++;
    bus.p0_read_req = 1'b0;
    wait_issue(ok);
    total++; if (bus.grant !== 1'b1 || bus.mem_write_req !== 1'b1 || bus.mem_read_req !== 1'b0)
      $display("FAIL simul_second_op: got grant=%b wr=%b rd=%b want 1 1 0", bus.grant, bus.mem_write_req, bus.mem_read_req);
    else passed++;
    total++; if (bus.mem_addr !== 32'h2000 || bus.mem_data_out !== 32'hDEAD_BEEF)
      $display("FAIL simul_second_bus: got addr=%h data=%h want 2000 deadbeef", bus.mem_addr, bus.mem_data_out);
    else passed++;
    finish_mem(2, {16{32'h5555_AAAA}});
    total++; if (bus.p1_ready !== 1'b1 || bus.p0_ready !== 1'b0)
      $display("FAIL simul_second_ready: got p1=%b p0=%b want 1 0", bus.p1_ready, bus.p0_ready);
    else passed++;
    // A write must leave the line buffer holding the previous read line.
    total++; if (bus.p1_rdata !== d) $display("FAIL simul_write_keeps_line: got %h want %h", bus.p1_rdata, d); else passed++;
    bus.p1_write_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [LINE_W-1:0] d;
    logic [31:0] w;
    logic exp_port;
    bit ok;
    do_reset();
    bus.p0_addr = 32'h0100; bus.p0_read_req = 1'b1;
    bus.p1_addr = 32'h0200; bus.p1_read_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_port = i[0];
      w = 32'hA000_0000 | i;
      d = {16{w}};
      wait_issue(ok);
      total++; if (bus.grant !== exp_port)
        $display("FAIL b2b_grant[%0d]: got %b want %b", i, bus.grant, exp_port);
      else passed++;
      total++; if (bus.mem_addr !== (exp_port ? 32'h0200 : 32'h0100))
        $display("FAIL b2b_addr[%0d]: got %h want %h", i, bus.mem_addr, exp_port ? 32'h0200 : 32'h0100);
      else passed++;
      finish_mem(1 + i, d);
      total++; if (bus.p0_ready !== ~exp_port || bus.p1_ready !== exp_port ||
                   (exp_port ? bus.p1_rdata : bus.p0_rdata) !== d)
        $display("FAIL b2b_done[%0d]: got p0=%b p1=%b data=%h want port %b data %h", i,
                 bus.p0_ready, bus.p1_ready, exp_port ? bus.p1_rdata : bus.p0_rdata, exp_port, d);
      else passed++;
    end
    bus.p0_read_req = 1'b0; bus.p1_read_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stray_and_abort();
    int r0;
    bit ok;
    do_reset();
    r0 = rdy_cnt;
    bus.mem_ready = 1'b1; bus.mem_data_in = '1;
    @(negedge clk);
    bus.mem_ready = 1'b0; bus.mem_data_in = '0;
    @(negedge clk);
    total++; if (bus.busy !== 1'b0 || bus.p0_ready !== 1'b0 || bus.p1_ready !== 1'b0)
      $display("FAIL stray_idle: got busy=%b p0=%b p1=%b want 0 0 0", bus.busy, bus.p0_ready, bus.p1_ready);
    else passed++;
    bus.p0_addr = 32'h4000; bus.p0_read_req = 1'b1;
    wait_issue(ok);
    bus.p0_read_req = 1'b0;
    @(negedge clk);
    total++; if (bus.busy !== 1'b1) $display("FAIL abort_in_wait: got busy=%b want 1", bus.busy); else passed++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (bus.busy !== 1'b0 || bus.grant !== 1'b0 || bus.mem_addr !== '0 || bus.mem_read_req !== 1'b0)
      $display("FAIL abort_outputs: got busy=%b grant=%b addr=%h rd=%b want 0 0 0 0",
               bus.busy, bus.grant, bus.mem_addr, bus.mem_read_req);
    else passed++;
    bus.mem_ready = 1'b1; bus.mem_data_in = '1;
    @(negedge clk);
    bus.mem_ready = 1'b0; bus.mem_data_in = '0;
    repeat (3) @(negedge clk);
    total++; if (bus.busy !== 1'b0) $display("FAIL late_ready_busy: got %b want 0", bus.busy); else passed++;
    total++; if (rdy_cnt - r0 !== 0) $display("FAIL abort_no_ready: got %0d pulses want 0", rdy_cnt - r0); else passed++;
  endtask

  task automatic test_read_write_both();
    int rd0, wr0;
    bit ok;
    rd0 = rd_cnt; wr0 = wr_cnt;
    bus.p1_addr = 32'h3000; bus.p1_wdata = 32'h0000_0055;
    bus.p1_read_req = 1'b1; bus.p1_write_req = 1'b1;
    wait_issue(ok);
    total++; if (bus.mem_write_req !== 1'b1 || bus.mem_read_req !== 1'b0 || bus.grant !== 1'b1 || bus.mem_addr !== 32'h3000)
      $display("FAIL rw_issue: got wr=%b rd=%b grant=%b addr=%h want 1 0 1 3000",
               bus.mem_write_req, bus.mem_read_req, bus.grant, bus.mem_addr);
    else passed++;
    finish_mem(1, {16{32'h1111_2222}});
    total++; if (bus.p1_ready !== 1'b1 || bus.p0_ready !== 1'b0)
      $display("FAIL rw_ready: got p1=%b p0=%b want 1 0", bus.p1_ready, bus.p0_ready);
    else passed++;
    bus.p1_read_req = 1'b0; bus.p1_write_req = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (rd_cnt - rd0 !== 0 || wr_cnt - wr0 !== 1)
      $display("FAIL rw_pulses: got rd=%0d wr=%0d want 0 1", rd_cnt - rd0, wr_cnt - wr0);
    else passed++;
  endtask

  task automatic test_timeout();
    bit ok;
    int r0;
    do_reset();
    r0 = rdy_cnt;
    bus.p0_addr = 32'h5000; bus.p0_read_req = 1'b1;
    wait_issue(ok);
`ifdef ARB_TIMEOUT_EN
    begin
      bit got;
      int n;
      got = 1'b0; n = 0;
      for (int i = 0; i < 30 && !got; i++) begin
        @(negedge clk);
        n++;
        if (bus.p0_ready === 1'b1) got = 1'b1;
      end
      // WAIT entered one edge after ISSUE; DONE 8 edges later.
      total++; if (!got || n != 9) $display("FAIL timeout_latency: got %0d cycles (seen=%b) want 9", n, got); else passed++;
      total++; if (bus.p0_err !== 1'b1 || bus.p1_ready !== 1'b0)
        $display("FAIL timeout_err: got err=%b p1=%b want 1 0", bus.p0_err, bus.p1_ready);
      else passed++;
      bus.p0_read_req = 1'b0;
      @(negedge clk);
      total++; if (bus.p0_err !== 1'b0 || bus.busy !== 1'b0)
        $display("FAIL timeout_after: got err=%b busy=%b want 0 0", bus.p0_err, bus.busy);
      else passed++;
    end
`else
    bus.p0_read_req = 1'b0;
    repeat (40) @(negedge clk);
    total++; if (bus.busy !== 1'b1) $display("FAIL no_timeout_busy: got %b want 1", bus.busy); else passed++;
    total++; if (rdy_cnt - r0 !== 0 || bus.p0_err !== 1'b0)
      $display("FAIL no_timeout_ready: got %0d pulses err=%b want 0 0", rdy_cnt - r0, bus.p0_err);
    else passed++;
    do_reset();
`endif
  endtask

  initial begin
    passed = 0; total = 0; rd_cnt = 0; wr_cnt = 0; rdy_cnt = 0;
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_simultaneous();
    test_back_to_back();
    test_stray_and_abort();
    test_read_write_both();
    test_timeout();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
